// File: rtl/cpu_pkg.sv
// Shared constants and types for the control sequencer: state and opcode
// encodings, register-file / ALU function codes, mux selects and the
// bundled control word driven by the decoder.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_FETCH_L = 3'd1,
        S_FETCH_H = 3'd2,
        S_EXEC1   = 3'd3,
        S_EXEC2   = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    typedef enum logic [5:0] {
        OP_BRA = 6'h00,
        OP_BNE = 6'h01,
        OP_BEQ = 6'h02,
        OP_LDI = 6'h03,
        OP_LD  = 6'h04,
        OP_ST  = 6'h05,
        OP_INC = 6'h06,
        OP_DEC = 6'h07,
        OP_ADD = 6'h08,
        OP_SUB = 6'h09,
        OP_AND = 6'h0A,
        OP_ORR = 6'h0B,
        OP_HLT = 6'h0C
    } opcode_t;

    // RF / ARF operation codes
    localparam logic [2:0] FUN_DEC   = 3'b000;
    localparam logic [2:0] FUN_INC   = 3'b001;
    localparam logic [2:0] FUN_LOAD  = 3'b010;
    localparam logic [2:0] FUN_CLEAR = 3'b011;

    // ALU operation codes
    localparam logic [4:0] ALU_PASS_A = 5'b10000;
    localparam logic [4:0] ALU_ADD    = 5'b10100;
    localparam logic [4:0] ALU_SUB    = 5'b10110;
    localparam logic [4:0] ALU_AND    = 5'b10111;
    localparam logic [4:0] ALU_OR     = 5'b11000;

    // MuxA / MuxB sources
    localparam logic [1:0] MUX_ALU  = 2'b00;
    localparam logic [1:0] MUX_OUTC = 2'b01;
    localparam logic [1:0] MUX_MEM  = 2'b10;
    localparam logic [1:0] MUX_IMM  = 2'b11;

    // MuxC: ALUOut[7:0] towards memory
    localparam logic MUXC_ALU_LOW = 1'b0;

    // ARF read selects
    localparam logic [1:0] ARF_PC = 2'b00;
    localparam logic [1:0] ARF_SP = 2'b01;
    localparam logic [1:0] ARF_AR = 2'b10;

    // ARF write enables {PC, AR, SP}
    localparam logic [2:0] ARF_EN_PC  = 3'b100;
    localparam logic [2:0] ARF_EN_AR  = 3'b010;
    localparam logic [2:0] ARF_EN_ALL = 3'b111;

    typedef struct packed {
        logic [2:0] rfOutASel;
        logic [2:0] rfOutBSel;
        logic [2:0] rfFunSel;
        logic [3:0] rfRegSel;
        logic [3:0] rfScrSel;
        logic [4:0] aluFunSel;
        logic       aluWf;
        logic [1:0] arfOutCSel;
        logic [1:0] arfOutDSel;
        logic [2:0] arfFunSel;
        logic [2:0] arfRegSel;
        logic       irLh;
        logic       irWrite;
        logic       memWr;
        logic       memCs;
        logic [1:0] muxASel;
        logic [1:0] muxBSel;
        logic       muxCSel;
    } ctrl_t;

    // Nothing enabled, memory deselected (Mem_CS is active-low)
    localparam ctrl_t CTRL_IDLE = '{
        rfOutASel:  3'b000,
        rfOutBSel:  3'b000,
        rfFunSel:   3'b000,
        rfRegSel:   4'b0000,
        rfScrSel:   4'b0000,
        aluFunSel:  5'b00000,
        aluWf:      1'b0,
        arfOutCSel: 2'b00,
        arfOutDSel: 2'b00,
        arfFunSel:  3'b000,
        arfRegSel:  3'b000,
        irLh:       1'b0,
        irWrite:    1'b0,
        memWr:      1'b0,
        memCs:      1'b1,
        muxASel:    2'b00,
        muxBSel:    2'b00,
        muxCSel:    1'b0
    };

    // Register index 0..3 (R1..R4) to write enable, R1 on bit 3
    function automatic logic [3:0] regOneHot(input logic [1:0] idx);
        return 4'b1000 >> idx;
    endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational decode of sequencer state plus instruction register into
// the full datapath control word.
module control_decoder
    import cpu_pkg::*;
(
    input  state_t      state,
    input  logic [15:0] irOut,
    input  logic [3:0]  flagOut,
    output ctrl_t       ctrl
);

    logic [5:0] opcode;
    logic [1:0] rSel;
    logic [1:0] dstReg;
    logic [1:0] srcReg1;
    logic [1:0] srcReg2;
    logic       zFlag;
    logic       takeBranch;
    logic       unusedBits;

    assign opcode  = irOut[15:10];
    assign rSel    = irOut[9:8];
    assign dstReg  = irOut[7:6];
    assign srcReg1 = irOut[4:3];
    assign srcReg2 = irOut[1:0];
    assign zFlag   = flagOut[3];

    // Only the low two bits of each register field address R1..R4; C, N, O
    // do not steer any instruction.
    assign unusedBits = ^{irOut[5], irOut[2], flagOut[2:0]};

    assign takeBranch = (opcode == OP_BRA)
                     || (opcode == OP_BNE && !zFlag)
                     || (opcode == OP_BEQ &&  zFlag);

    // Control word for the current state and instruction
    always_comb begin
        // NOTE: every output gets a default before the case so that paths that
        // assign nothing (NOP, untaken branch) cannot infer a latch.
        ctrl = CTRL_IDLE;
        case (state)
            S_INIT: begin
                ctrl.rfRegSel  = 4'b1111;
                ctrl.rfScrSel  = 4'b1111;
                ctrl.rfFunSel  = FUN_CLEAR;
                ctrl.arfRegSel = ARF_EN_ALL;
                ctrl.arfFunSel = FUN_CLEAR;
            end
            S_FETCH_L, S_FETCH_H: begin
                ctrl.arfOutDSel = ARF_PC;
                ctrl.memCs      = 1'b0;
                ctrl.irWrite    = 1'b1;
                ctrl.irLh       = (state == S_FETCH_H);
                ctrl.arfRegSel  = ARF_EN_PC;
                ctrl.arfFunSel  = FUN_INC;
            end
            S_EXEC1: begin
                case (opcode)
                    OP_BRA, OP_BNE, OP_BEQ: begin
                        if (takeBranch) begin
                            ctrl.muxBSel   = MUX_IMM;
                            ctrl.arfRegSel = ARF_EN_PC;
                            ctrl.arfFunSel = FUN_LOAD;
                        end
                    end
                    OP_LDI: begin
                        ctrl.muxASel  = MUX_IMM;
                        ctrl.rfRegSel = regOneHot(rSel);
                        ctrl.rfFunSel = FUN_LOAD;
                    end
                    OP_LD, OP_ST: begin
                        ctrl.muxBSel   = MUX_IMM;
                        ctrl.arfRegSel = ARF_EN_AR;
                        ctrl.arfFunSel = FUN_LOAD;
                    end
                    OP_INC, OP_DEC: begin
                        ctrl.rfRegSel = regOneHot(dstReg);
                        ctrl.rfFunSel = (opcode == OP_INC) ? FUN_INC : FUN_DEC;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                        ctrl.rfOutASel = {1'b0, srcReg1};
                        ctrl.rfOutBSel = {1'b0, srcReg2};
                        ctrl.muxASel   = MUX_ALU;
                        ctrl.rfRegSel  = regOneHot(dstReg);
                        ctrl.rfFunSel  = FUN_LOAD;
                        ctrl.aluWf     = 1'b1;
                        case (opcode)
                            OP_ADD:  ctrl.aluFunSel = ALU_ADD;
                            OP_SUB:  ctrl.aluFunSel = ALU_SUB;
                            OP_AND:  ctrl.aluFunSel = ALU_AND;
                            default: ctrl.aluFunSel = ALU_OR;
                        endcase
                    end
                    default: ;  // HLT and unassigned opcodes drive nothing
                endcase
            end
            S_EXEC2: begin
                if (opcode == OP_LD) begin
                    ctrl.arfOutDSel = ARF_AR;
                    ctrl.memCs      = 1'b0;
                    ctrl.muxASel    = MUX_MEM;
                    ctrl.rfRegSel   = regOneHot(rSel);
                    ctrl.rfFunSel   = FUN_LOAD;
                end else if (opcode == OP_ST) begin
                    // The store address comes from AR, loaded in EXEC1
                    ctrl.arfOutDSel = ARF_AR;
                    ctrl.rfOutASel  = {1'b0, rSel};
                    ctrl.aluFunSel  = ALU_PASS_A;
                    ctrl.muxCSel    = MUXC_ALU_LOW;
                    ctrl.memCs      = 1'b0;
                    ctrl.memWr      = 1'b1;
                end
            end
            default: ;  // HALT and unused encodings stay idle
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: INIT, two-byte fetch, one or two execute
// steps, and HALT. Holds the state register and next-state logic; control
// outputs come from control_decoder and are forced idle while Reset is high.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  FlagOut,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [2:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  RF_ScrSel,
    output logic [4:0]  ALU_FunSel,
    output logic        ALU_WF,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [2:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Write,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic [2:0]  State
);

    state_t     stateQ;
    state_t     stateD;
    ctrl_t      decoded;
    ctrl_t      ctrl;
    logic [5:0] opcode;

    assign opcode = IROut[15:10];

    control_decoder u_decoder (
        .state   (stateQ),
        .irOut   (IROut),
        .flagOut (FlagOut),
        .ctrl    (decoded)
    );

    // State register with synchronous reset to INIT
    always_ff @(posedge Clock) begin
        // NOTE: state is updated with non-blocking assignments; the reset is
        // sampled on the clock edge, so it is not in the sensitivity list.
        if (Reset) begin
            stateQ <= S_INIT;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state: fetch two bytes, execute one step (two for LD/ST), repeat
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            S_INIT:    stateD = S_FETCH_L;
            S_FETCH_L: stateD = S_FETCH_H;
            S_FETCH_H: stateD = S_EXEC1;
            S_EXEC1: begin
                if (opcode == OP_LD || opcode == OP_ST) begin
                    stateD = S_EXEC2;
                end else if (opcode == OP_HLT) begin
                    stateD = S_HALT;
                end else begin
                    stateD = S_FETCH_L;
                end
            end
            S_EXEC2:   stateD = S_FETCH_L;
            S_HALT:    stateD = S_HALT;
            default:   stateD = S_INIT;
        endcase
    end

    // Reset overrides the decoded controls within the same cycle
    assign ctrl = Reset ? CTRL_IDLE : decoded;

    assign RF_OutASel  = ctrl.rfOutASel;
    assign RF_OutBSel  = ctrl.rfOutBSel;
    assign RF_FunSel   = ctrl.rfFunSel;
    assign RF_RegSel   = ctrl.rfRegSel;
    assign RF_ScrSel   = ctrl.rfScrSel;
    assign ALU_FunSel  = ctrl.aluFunSel;
    assign ALU_WF      = ctrl.aluWf;
    assign ARF_OutCSel = ctrl.arfOutCSel;
    assign ARF_OutDSel = ctrl.arfOutDSel;
    assign ARF_FunSel  = ctrl.arfFunSel;
    assign ARF_RegSel  = ctrl.arfRegSel;
    assign IR_LH       = ctrl.irLh;
    assign IR_Write    = ctrl.irWrite;
    assign Mem_WR      = ctrl.memWr;
    assign Mem_CS      = ctrl.memCs;
    assign MuxASel     = ctrl.muxASel;
    assign MuxBSel     = ctrl.muxBSel;
    assign MuxCSel     = ctrl.muxCSel;
    assign State       = stateQ;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus a
// randomized instruction stream, checked against an instruction-level
// reference model of the expected control word in each step.
module tb_control_sequencer;

    // Bench-side view of all control outputs, in a fixed order
    typedef struct packed {
        logic [2:0] rfOutASel;
        logic [2:0] rfOutBSel;
        logic [2:0] rfFunSel;
        logic [3:0] rfRegSel;
        logic [3:0] rfScrSel;
        logic [4:0] aluFunSel;
        logic       aluWf;
        logic [1:0] arfOutCSel;
        logic [1:0] arfOutDSel;
        logic [2:0] arfFunSel;
        logic [2:0] arfRegSel;
        logic       irLh;
        logic       irWrite;
        logic       memWr;
        logic       memCs;
        logic [1:0] muxASel;
        logic [1:0] muxBSel;
        logic       muxCSel;
    } sig_t;

    // Instruction steps as seen from outside
    localparam int STEP_INIT  = 0;
    localparam int STEP_FL    = 1;
    localparam int STEP_FH    = 2;
    localparam int STEP_E1    = 3;
    localparam int STEP_E2    = 4;
    localparam int STEP_IDLE  = 5;

    logic        Clock;
    logic        Reset;
    logic [15:0] IROut;
    logic [3:0]  FlagOut;
    logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
    logic [3:0]  RF_RegSel, RF_ScrSel;
    logic [4:0]  ALU_FunSel;
    logic        ALU_WF;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel;
    logic [2:0]  ARF_FunSel, ARF_RegSel;
    logic        IR_LH, IR_Write, Mem_WR, Mem_CS;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel;
    logic [2:0]  State;

    sig_t obs;
    sig_t lastE1;
    sig_t lastE2;
    int   total = 0;
    int   bad   = 0;

    control_sequencer dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .IROut       (IROut),
        .FlagOut     (FlagOut),
        .RF_OutASel  (RF_OutASel),
        .RF_OutBSel  (RF_OutBSel),
        .RF_FunSel   (RF_FunSel),
        .RF_RegSel   (RF_RegSel),
        .RF_ScrSel   (RF_ScrSel),
        .ALU_FunSel  (ALU_FunSel),
        .ALU_WF      (ALU_WF),
        .ARF_OutCSel (ARF_OutCSel),
        .ARF_OutDSel (ARF_OutDSel),
        .ARF_FunSel  (ARF_FunSel),
        .ARF_RegSel  (ARF_RegSel),
        .IR_LH       (IR_LH),
        .IR_Write    (IR_Write),
        .Mem_WR      (Mem_WR),
        .Mem_CS      (Mem_CS),
        .MuxASel     (MuxASel),
        .MuxBSel     (MuxBSel),
        .MuxCSel     (MuxCSel),
        .State       (State)
    );

    assign obs = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
                  ALU_FunSel, ALU_WF, ARF_OutCSel, ARF_OutDSel, ARF_FunSel,
                  ARF_RegSel, IR_LH, IR_Write, Mem_WR, Mem_CS,
                  MuxASel, MuxBSel, MuxCSel};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // ---------------- reference model ----------------

    function automatic sig_t idleWord();
        sig_t s = '0;
        s.memCs = 1'b1;
        return s;
    endfunction

    // Write enable for register number n (0 = R1 on bit 3)
    function automatic logic [3:0] regWe(input int n);
        case (n)
            0:       return 4'b1000;
            1:       return 4'b0100;
            2:       return 4'b0010;
            default: return 4'b0001;
        endcase
    endfunction

    function automatic int stepsFor(input logic [15:0] ir);
        int op = int'(ir[15:10]);
        return (op == 4 || op == 5) ? 4 : 3;
    endfunction

    // Expected control word for one externally visible step of instruction ir
    function automatic sig_t model(input int step, input logic [15:0] ir,
                                   input logic z);
        sig_t s   = idleWord();
        int   op  = int'(ir[15:10]);
        int   rs  = int'(ir[9:8]);
        int   dst = int'(ir[7:6]);
        int   a   = int'(ir[4:3]);
        int   b   = int'(ir[1:0]);
        bit   branch;
        if (step == STEP_INIT) begin
            s.rfRegSel  = 4'b1111;
            s.rfScrSel  = 4'b1111;
            s.arfRegSel = 3'b111;
            s.rfFunSel  = 3'b011;
            s.arfFunSel = 3'b011;
        end else if (step == STEP_FL || step == STEP_FH) begin
            s.arfOutDSel = 2'b00;
            s.memCs      = 1'b0;
            s.irWrite    = 1'b1;
            s.irLh       = (step == STEP_FH);
            s.arfFunSel  = 3'b001;
            s.arfRegSel  = 3'b100;
        end else if (step == STEP_E1) begin
            branch = (op == 0) || (op == 1 && !z) || (op == 2 && z);
            if (branch) begin
                s.muxBSel = 2'b11; s.arfRegSel = 3'b100; s.arfFunSel = 3'b010;
            end else if (op == 3) begin
                s.muxASel = 2'b11; s.rfRegSel = regWe(rs); s.rfFunSel = 3'b010;
            end else if (op == 4 || op == 5) begin
                s.muxBSel = 2'b11; s.arfRegSel = 3'b010; s.arfFunSel = 3'b010;
            end else if (op == 6 || op == 7) begin
                s.rfRegSel = regWe(dst);
                s.rfFunSel = (op == 6) ? 3'b001 : 3'b000;
            end else if (op >= 8 && op <= 11) begin
                s.rfOutASel = 3'(a);
                s.rfOutBSel = 3'(b);
                s.muxASel   = 2'b00;
                s.rfRegSel  = regWe(dst);
                s.rfFunSel  = 3'b010;
                s.aluWf     = 1'b1;
                s.aluFunSel = (op == 8) ? 5'b10100 : (op == 9) ? 5'b10110 :
                              (op == 10) ? 5'b10111 : 5'b11000;
            end
        end else if (step == STEP_E2) begin
            if (op == 4) begin
                s.arfOutDSel = 2'b10; s.memCs = 1'b0; s.muxASel = 2'b10;
                s.rfRegSel = regWe(rs); s.rfFunSel = 3'b010;
            end else if (op == 5) begin
                s.arfOutDSel = 2'b10; s.rfOutASel = 3'(rs);
                s.aluFunSel = 5'b10000; s.muxCSel = 1'b0;
                s.memCs = 1'b0; s.memWr = 1'b1;
            end
        end
        return s;
    endfunction

    // ---------------- stimulus helpers ----------------

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Runs one instruction from FETCH_L through its last execute step,
    // comparing the control word in every step.
    task automatic runInstr(input logic [15:0] ir, input logic z,
                            input string tag);
        sig_t exp;
        int   n = stepsFor(ir);
        IROut   = ir;
        FlagOut = {z, 3'($urandom)};
        for (int k = 0; k < n; k++) begin
            #1;
            exp = model(k + 1, ir, z);
            if (k + 1 == STEP_E1) lastE1 = obs;
            if (k + 1 == STEP_E2) lastE2 = obs;
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL %s step=%0d ir=%h z=%0b got=%h want=%h",
                         tag, k + 1, ir, z, obs, exp);
            end
            tick();
        end
    endtask

    // ---------------- scenarios ----------------

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        total++;
        if (obs !== idleWord()) begin
            bad++;
            $display("FAIL reset_idle got=%h want=%h", obs, idleWord());
        end
        Reset = 1'b0;
        #1;
        total++;
        if (obs !== model(STEP_INIT, 16'h0, 1'b0)) begin
            bad++;
            $display("FAIL reset_init got=%h want=%h", obs,
                     model(STEP_INIT, 16'h0, 1'b0));
        end
        tick();
        #1;
        total++;
        if (Mem_CS !== 1'b0 || ARF_OutDSel !== 2'b00 || IR_Write !== 1'b1) begin
            bad++;
            $display("FAIL reset_fetch cs=%b dsel=%b irw=%b want cs=0 dsel=00 irw=1",
                     Mem_CS, ARF_OutDSel, IR_Write);
        end
    endtask

    task automatic test_ldi();
        runInstr(16'h0C5A, 1'b0, "ldi");
        total++;
        if (lastE1.rfRegSel !== 4'b1000 || lastE1.rfFunSel !== 3'b010 ||
            lastE1.muxASel !== 2'b11) begin
            bad++;
            $display("FAIL ldi_exec1 regsel=%b fun=%b muxa=%b want 1000 010 11",
                     lastE1.rfRegSel, lastE1.rfFunSel, lastE1.muxASel);
        end
        #1;
        total++;
        if (obs !== model(STEP_FL, 16'h0, 1'b0)) begin
            bad++;
            $display("FAIL ldi_next got=%h want=%h", obs, model(STEP_FL, 16'h0, 1'b0));
        end
    endtask

    task automatic test_branch();
        runInstr(16'h0820, 1'b1, "beq_taken");
        total++;
        if (lastE1.arfRegSel !== 3'b100 || lastE1.arfFunSel !== 3'b010) begin
            bad++;
            $display("FAIL beq_taken arfreg=%b fun=%b want 100 010",
                     lastE1.arfRegSel, lastE1.arfFunSel);
        end
        runInstr(16'h0820, 1'b0, "beq_not");
        total++;
        if (lastE1 !== idleWord()) begin
            bad++;
            $display("FAIL beq_not got=%h want=%h", lastE1, idleWord());
        end
        runInstr(16'h0410, 1'b0, "bne_taken");
        runInstr(16'h0410, 1'b1, "bne_not");
        runInstr(16'h00FF, 1'b1, "bra");
    endtask

    task automatic test_store();
        runInstr(16'h1420, 1'b0, "st");
        total++;
        if (lastE1.arfRegSel !== 3'b010 || lastE1.arfFunSel !== 3'b010) begin
            bad++;
            $display("FAIL st_exec1 arfreg=%b fun=%b want 010 010",
                     lastE1.arfRegSel, lastE1.arfFunSel);
        end
        total++;
        if (lastE2.memWr !== 1'b1 || lastE2.memCs !== 1'b0 ||
            lastE2.aluFunSel !== 5'b10000) begin
            bad++;
            $display("FAIL st_exec2 wr=%b cs=%b alu=%b want 1 0 10000",
                     lastE2.memWr, lastE2.memCs, lastE2.aluFunSel);
        end
    endtask

    task automatic test_alu();
        // ADD R3 <- R2 + R4
        runInstr(16'h208B, 1'b0, "add");
        total++;
        if (lastE1.rfRegSel !== 4'b0010 || lastE1.aluWf !== 1'b1 ||
            lastE1.aluFunSel !== 5'b10100 || lastE1.rfOutASel !== 3'b001 ||
            lastE1.rfOutBSel !== 3'b011) begin
            bad++;
            $display("FAIL add_exec1 got=%h want=%h", lastE1, model(STEP_E1, 16'h208B, 1'b0));
        end
    endtask

    task automatic test_halt();
        logic [2:0] haltState;
        runInstr(16'h3000, 1'b0, "hlt");
        #1;
        haltState = State;
        for (int i = 0; i < 10; i++) begin
            FlagOut = 4'($urandom);
            #1;
            total++;
            if (obs !== idleWord() || State !== haltState) begin
                bad++;
                $display("FAIL halt_hold cyc=%0d got=%h state=%0d want=%h state=%0d",
                         i, obs, State, idleWord(), haltState);
            end
            tick();
        end
        Reset = 1'b1;
        #1;
        total++;
        if (obs !== idleWord()) begin
            bad++;
            $display("FAIL halt_reset_idle got=%h want=%h", obs, idleWord());
        end
        tick();
        Reset = 1'b0;
        #1;
        total++;
        if (obs !== model(STEP_INIT, 16'h0, 1'b0)) begin
            bad++;
            $display("FAIL halt_reset_init got=%h want=%h", obs,
                     model(STEP_INIT, 16'h0, 1'b0));
        end
        tick();
    endtask

    task automatic test_reset_mid_ld();
        logic [15:0] ir = 16'h1120;
        sig_t        exp;
        IROut   = ir;
        FlagOut = 4'b0000;
        for (int k = STEP_FL; k <= STEP_E1; k++) begin
            #1;
            exp = model(k, ir, 1'b0);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL ld_pre step=%0d got=%h want=%h", k, obs, exp);
            end
            tick();
        end
        Reset = 1'b1;
        #1;
        total++;
        if (obs !== idleWord()) begin
            bad++;
            $display("FAIL ld_reset_idle got=%h want=%h", obs, idleWord());
        end
        tick();
        Reset = 1'b0;
        #1;
        total++;
        if (obs !== model(STEP_INIT, ir, 1'b0)) begin
            bad++;
            $display("FAIL ld_reset_init got=%h want=%h", obs, model(STEP_INIT, ir, 1'b0));
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [5:0]  op;
        logic [15:0] ir;
        for (int i = 0; i < 60; i++) begin
            op = 6'($urandom_range(0, 63));
            if (op == 6'h0C) op = 6'h0D;
            ir = {op, 10'($urandom)};
            runInstr(ir, 1'($urandom), "random");
        end
    endtask

    initial begin
        Reset   = 1'b1;
        IROut   = 16'h0000;
        FlagOut = 4'b0000;
        test_reset();
        tick();          // leave FETCH_L of the reset check
        tick();          // FETCH_H
        tick();          // EXEC1 of NOP 0x0000 is BRA; consumed as filler
        test_ldi();
        test_branch();
        test_store();
        test_alu();
        test_back_to_back();
        test_halt();
        test_reset_mid_ld();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
